// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding, stall and flush.
// Optional: define ID_EX_STALL_CNT_EN to add a 32-bit stall_cnt output.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_rs1_data,
    input  logic [XLEN-1:0]   in_rs2_data,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [REG_AW-1:0] in_rs1_addr,
    input  logic [REG_AW-1:0] in_rs2_addr,
    input  logic [REG_AW-1:0] in_rd_addr,
    input  logic [3:0]        in_alu_ctrl,
    input  logic              in_src_a_pc,
    input  logic              in_src_b_imm,
    input  logic              in_reg_write,
    input  logic              flush,
    input  logic              ex_stall,
    input  logic              fwd_mem_we,
    input  logic [REG_AW-1:0] fwd_mem_rd,
    input  logic [XLEN-1:0]   fwd_mem_data,
    input  logic              fwd_wb_we,
    input  logic [REG_AW-1:0] fwd_wb_rd,
    input  logic [XLEN-1:0]   fwd_wb_data,
`ifdef ID_EX_STALL_CNT_EN
    output logic [31:0]       stall_cnt,
`endif
    output logic              out_valid,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    output logic [3:0]        alu_ctrl,
    output logic [XLEN-1:0]   store_data,
    output logic [XLEN-1:0]   pc_out,
    output logic [REG_AW-1:0] rd_out,
    output logic              reg_write_out
);

    logic              valid_q, valid_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   rs1_q, rs1_d;
    logic [XLEN-1:0]   rs2_q, rs2_d;
    logic [XLEN-1:0]   imm_q, imm_d;
    logic [REG_AW-1:0] rs1_addr_q, rs1_addr_d;
    logic [REG_AW-1:0] rs2_addr_q, rs2_addr_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [3:0]        ctrl_q, ctrl_d;
    logic              src_a_pc_q, src_a_pc_d;
    logic              src_b_imm_q, src_b_imm_d;
    logic              reg_write_q, reg_write_d;

    logic              capture;
    logic [XLEN-1:0]   fwd_rs1;
    logic [XLEN-1:0]   fwd_rs2;

    assign in_ready = !valid_q || !ex_stall;
    assign capture  = in_valid && in_ready;

    // Forward newest producer (MEM over WB); x0 always reads the held value.
    always_comb begin
        fwd_rs1 = rs1_q;
        if (fwd_mem_we && fwd_mem_rd == rs1_addr_q && rs1_addr_q != '0)
            fwd_rs1 = fwd_mem_data;
        else if (fwd_wb_we && fwd_wb_rd == rs1_addr_q && rs1_addr_q != '0)
            fwd_rs1 = fwd_wb_data;
        fwd_rs2 = rs2_q;
        if (fwd_mem_we && fwd_mem_rd == rs2_addr_q && rs2_addr_q != '0)
            fwd_rs2 = fwd_mem_data;
        else if (fwd_wb_we && fwd_wb_rd == rs2_addr_q && rs2_addr_q != '0)
            fwd_rs2 = fwd_wb_data;
    end

    // Next state: flush, then capture, then bubble, else hold with refresh.
    always_comb begin
        valid_d     = valid_q;
        pc_d        = pc_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        imm_d       = imm_q;
        rs1_addr_d  = rs1_addr_q;
        rs2_addr_d  = rs2_addr_q;
        rd_d        = rd_q;
        ctrl_d      = ctrl_q;
        src_a_pc_d  = src_a_pc_q;
        src_b_imm_d = src_b_imm_q;
        reg_write_d = reg_write_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (capture) begin
            valid_d     = 1'b1;
            pc_d        = in_pc;
            rs1_d       = in_rs1_data;
            rs2_d       = in_rs2_data;
            imm_d       = in_imm;
            rs1_addr_d  = in_rs1_addr;
            rs2_addr_d  = in_rs2_addr;
            rd_d        = in_rd_addr;
            ctrl_d      = in_alu_ctrl;
            src_a_pc_d  = in_src_a_pc;
            src_b_imm_d = in_src_b_imm;
            reg_write_d = in_reg_write;
        end else if (valid_q && !ex_stall) begin
            valid_d = 1'b0;
        end else if (valid_q && ex_stall) begin
            // Keep forwarded values once the producer leaves WB.
            rs1_d = fwd_rs1;
            rs2_d = fwd_rs2;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            imm_q       <= '0;
            rs1_addr_q  <= '0;
            rs2_addr_q  <= '0;
            rd_q        <= '0;
            ctrl_q      <= '0;
            src_a_pc_q  <= 1'b0;
            src_b_imm_q <= 1'b0;
            reg_write_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            imm_q       <= imm_d;
            rs1_addr_q  <= rs1_addr_d;
            rs2_addr_q  <= rs2_addr_d;
            rd_q        <= rd_d;
            ctrl_q      <= ctrl_d;
            src_a_pc_q  <= src_a_pc_d;
            src_b_imm_q <= src_b_imm_d;
            reg_write_q <= reg_write_d;
        end
    end

`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    // Count cycles spent holding a live instruction.
    always_comb begin
        cnt_d = cnt_q;
        if (valid_q && ex_stall && !flush)
            cnt_d = cnt_q + 32'd1;
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign stall_cnt = cnt_q;
`endif

    assign out_valid     = valid_q;
    assign alu_a         = src_a_pc_q ? pc_q : fwd_rs1;
    assign alu_b         = src_b_imm_q ? imm_q : fwd_rs2;
    assign alu_ctrl      = valid_q ? ctrl_q : 4'b0000;
    assign store_data    = fwd_rs2;
    assign pc_out        = pc_q;
    assign rd_out        = rd_q;
    assign reg_write_out = valid_q && reg_write_q;

endmodule
